// File: rtl/npu_pkg.sv
// Shared NPU definitions: circular-buffer FSM states and sticky error bit positions.
package npu_pkg;

  typedef enum logic [1:0] {
    CBUF_EMPTY = 2'd0,
    CBUF_LOAD  = 2'd1,
    CBUF_RUN   = 2'd2
  } cbuf_state_t;

  localparam int CBUF_ERR_W    = 4;
  localparam int CBUF_ERR_OVF  = 0;
  localparam int CBUF_ERR_UDF  = 1;
  localparam int CBUF_ERR_CONF = 2;
  localparam int CBUF_ERR_WRUN = 3;

endpackage

// File: rtl/npu_circ_buf_param_if.sv
// Load/replay bus of the NPU circular buffer: config-side requests plus status and replay data.
interface npu_circ_buf_param_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  import npu_pkg::*;

  // write_en / read_en are single-cycle requests with no ready: the block either
  // accepts a request on the edge or drops it and records a sticky err bit.
  // data_valid pulses for exactly one cycle, one cycle after each accepted read.
  logic                  npu_cbuf_clear;
  logic                  npu_cbuf_write_en;
  logic [DATA_W-1:0]     npu_cbuf_data_in;
  logic                  npu_cbuf_read_en;
  logic [DATA_W-1:0]     npu_cbuf_data_out;
  logic                  npu_cbuf_data_valid;
  logic                  npu_cbuf_rev_done;
  logic [CNT_W-1:0]      npu_cbuf_count;
  logic                  npu_cbuf_full;
  logic                  npu_cbuf_empty;
  logic [CBUF_ERR_W-1:0] npu_cbuf_err;
  cbuf_state_t           npu_cbuf_state;

  modport master (
    output npu_cbuf_clear, npu_cbuf_write_en, npu_cbuf_data_in, npu_cbuf_read_en,
    input  npu_cbuf_data_out, npu_cbuf_data_valid, npu_cbuf_rev_done, npu_cbuf_count,
           npu_cbuf_full, npu_cbuf_empty, npu_cbuf_err, npu_cbuf_state
  );

  modport slave (
    input  npu_cbuf_clear, npu_cbuf_write_en, npu_cbuf_data_in, npu_cbuf_read_en,
    output npu_cbuf_data_out, npu_cbuf_data_valid, npu_cbuf_rev_done, npu_cbuf_count,
           npu_cbuf_full, npu_cbuf_empty, npu_cbuf_err, npu_cbuf_state
  );

endinterface

// File: rtl/npu_cbuf_ram.sv
// Simple dual-port storage, no reset. A recirculating write copies the word at rd_addr to wr_addr.
module npu_cbuf_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic              wr_recirc,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Copy and read both use the pre-edge contents, so head == tail leaves the word intact.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_recirc ? mem[rd_addr] : wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/npu_circ_buf_param.sv
// Load-once, replay-forever circular buffer for NPU weight/schedule streams.
module npu_circ_buf_param
  import npu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic                CLK,
  input logic                npu_rst,
  npu_circ_buf_param_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  cbuf_state_t           state_q, state_d;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, rev_idx_q;
  logic [CBUF_ERR_W-1:0] err_q, err_set;
  logic                  valid_q, rev_done_q, out_zero_q;
  logic                  full, empty, clear;
  logic                  wr_req, rd_req, wr_acc, rd_acc, rev_last;
  logic [DATA_W-1:0]     ram_rdata;

  assign clear    = bus.npu_cbuf_clear;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign rev_last = (rev_idx_q == count_q - CNT_W'(1));

  // A simultaneous write and read is a conflict; neither side executes.
  assign wr_req = bus.npu_cbuf_write_en & ~bus.npu_cbuf_read_en & ~clear;
  assign rd_req = bus.npu_cbuf_read_en & ~bus.npu_cbuf_write_en & ~clear;
  assign wr_acc = wr_req && (state_q != CBUF_RUN) && !full;
  assign rd_acc = rd_req && (state_q != CBUF_EMPTY);

  always_comb begin
    err_set                = '0;
    err_set[CBUF_ERR_OVF]  = wr_req && (state_q != CBUF_RUN) && full;
    err_set[CBUF_ERR_UDF]  = rd_req && (state_q == CBUF_EMPTY);
    err_set[CBUF_ERR_CONF] = bus.npu_cbuf_write_en & bus.npu_cbuf_read_en & ~clear;
    err_set[CBUF_ERR_WRUN] = wr_req && (state_q == CBUF_RUN);
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = CBUF_EMPTY;
    end else begin
      case (state_q)
        CBUF_EMPTY: if (wr_acc) state_d = CBUF_LOAD;
        CBUF_LOAD:  if (rd_acc) state_d = CBUF_RUN;
        CBUF_RUN:   state_d = CBUF_RUN;
        default:    state_d = CBUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (npu_rst) state_q <= CBUF_EMPTY;
    else         state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rev_idx_q  <= '0;
      err_q      <= '0;
      valid_q    <= 1'b0;
      rev_done_q <= 1'b0;
      out_zero_q <= 1'b1;
    end else if (clear) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rev_idx_q  <= '0;
      valid_q    <= 1'b0;
      rev_done_q <= 1'b0;
    end else begin
      err_q      <= err_q | err_set;
      valid_q    <= rd_acc;
      rev_done_q <= rd_acc && rev_last;
      if (wr_acc) begin
        tail_q  <= tail_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(1);
        if (state_q == CBUF_EMPTY) rev_idx_q <= '0;
      end
      if (rd_acc) begin
        head_q     <= head_q + PTR_W'(1);
        tail_q     <= tail_q + PTR_W'(1);
        rev_idx_q  <= rev_last ? '0 : rev_idx_q + CNT_W'(1);
        out_zero_q <= 1'b0;
      end
    end
  end

  npu_cbuf_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PTR_W)) u_ram (
    .CLK       (CLK),
    .wr_en     (wr_acc | rd_acc),
    .wr_recirc (rd_acc),
    .wr_addr   (tail_q),
    .wr_data   (bus.npu_cbuf_data_in),
    .rd_en     (rd_acc),
    .rd_addr   (head_q),
    .rd_data   (ram_rdata)
  );

  // RAM output has no reset; mask it until the first read after reset.
  assign bus.npu_cbuf_data_out   = out_zero_q ? '0 : ram_rdata;
  assign bus.npu_cbuf_data_valid = valid_q;
  assign bus.npu_cbuf_rev_done   = rev_done_q;
  assign bus.npu_cbuf_count      = count_q;
  assign bus.npu_cbuf_full       = full;
  assign bus.npu_cbuf_empty      = empty;
  assign bus.npu_cbuf_err        = err_q;
  assign bus.npu_cbuf_state      = state_q;

endmodule

// File: tb/tb_npu_circ_buf_param.sv
// Bench for npu_circ_buf_param: directed scenarios plus random traffic against a queue-based model.
module tb_npu_circ_buf_param;
  import npu_pkg::*;

  localparam int DW  = 16;
  localparam int DP  = 8;
  localparam int DW2 = 32;
  localparam int DP2 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  npu_circ_buf_param_if #(.DATA_W(DW),  .DEPTH(DP))  bus_a ();
  npu_circ_buf_param_if #(.DATA_W(DW2), .DEPTH(DP2)) bus_b ();

  npu_circ_buf_param #(.DATA_W(DW), .DEPTH(DP)) dut_a (
    .CLK (clk), .npu_rst (rst), .bus (bus_a.slave)
  );
  npu_circ_buf_param #(.DATA_W(DW2), .DEPTH(DP2)) dut_b (
    .CLK (clk), .npu_rst (rst), .bus (bus_b.slave)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_q[$];
  int            rd_n;
  logic          running;
  logic [3:0]    m_err;
  logic [DW-1:0] m_dout;
  logic          m_valid, m_rev;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    rd_n    = 0;
    running = 1'b0;
    m_err   = '0;
    m_dout  = '0;
    m_valid = 1'b0;
    m_rev   = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [DW-1:0] wd, input logic re, input logic clr);
    logic [DW-1:0] w;
    m_valid = 1'b0;
    m_rev   = 1'b0;
    if (clr) begin
      exp_q.delete();
      running = 1'b0;
    end else if (we && re) begin
      m_err[2] = 1'b1;
    end else if (we) begin
      if (running)                  m_err[3] = 1'b1;
      else if (exp_q.size() == DP)  m_err[0] = 1'b1;
      else begin
        if (exp_q.size() == 0) rd_n = 0;
        exp_q.push_back(wd);
      end
    end else if (re) begin
      if (exp_q.size() == 0) m_err[1] = 1'b1;
      else begin
        w = exp_q.pop_front();
        exp_q.push_back(w);
        m_dout  = w;
        m_valid = 1'b1;
        rd_n++;
        m_rev   = ((rd_n % exp_q.size()) == 0);
        running = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic check_outputs(input string tag);
    cbuf_state_t es;
    es = (exp_q.size() == 0) ? CBUF_EMPTY : (running ? CBUF_RUN : CBUF_LOAD);
    check_val({tag, ".count"}, 32'(bus_a.npu_cbuf_count), 32'(exp_q.size()));
    check_val({tag, ".empty"}, 32'(bus_a.npu_cbuf_empty), 32'(exp_q.size() == 0));
    check_val({tag, ".full"},  32'(bus_a.npu_cbuf_full),  32'(exp_q.size() == DP));
    check_val({tag, ".err"},   32'(bus_a.npu_cbuf_err),   32'(m_err));
    check_val({tag, ".valid"}, 32'(bus_a.npu_cbuf_data_valid), 32'(m_valid));
    check_val({tag, ".rev"},   32'(bus_a.npu_cbuf_rev_done),   32'(m_rev));
    check_val({tag, ".dout"},  32'(bus_a.npu_cbuf_data_out),   32'(m_dout));
    check_val({tag, ".state"}, 32'(bus_a.npu_cbuf_state),      32'(es));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input logic we, input logic [DW-1:0] wd,
                      input logic re, input logic clr);
    bus_a.npu_cbuf_write_en = we;
    bus_a.npu_cbuf_data_in  = wd;
    bus_a.npu_cbuf_read_en  = re;
    bus_a.npu_cbuf_clear    = clr;
    model_step(we, wd, re, clr);
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  // Leaves bus_a inputs as driven so reset can land mid-transaction.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_outputs(tag);
    rst = 1'b0;
    bus_a.npu_cbuf_write_en = 1'b0;
    bus_a.npu_cbuf_read_en  = 1'b0;
    bus_a.npu_cbuf_clear    = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [DW-1:0] d); step(tag, 1'b1, d, 1'b0, 1'b0); endtask
  task automatic rd(input string tag);                         step(tag, 1'b0, '0, 1'b1, 1'b0); endtask

  // ---------------- stimulus ----------------
  logic [DW2-1:0] exp_b[$];

  initial begin
    bus_a.npu_cbuf_write_en = 1'b0;
    bus_a.npu_cbuf_read_en  = 1'b0;
    bus_a.npu_cbuf_clear    = 1'b0;
    bus_a.npu_cbuf_data_in  = '0;
    bus_b.npu_cbuf_write_en = 1'b0;
    bus_b.npu_cbuf_read_en  = 1'b0;
    bus_b.npu_cbuf_clear    = 1'b0;
    bus_b.npu_cbuf_data_in  = '0;
    repeat (2) @(posedge clk);
    #1;

    // basic rotation with revolution markers
    do_reset("rst1");
    wr("ld", 16'h0011); wr("ld", 16'h0022); wr("ld", 16'h0033);
    for (int i = 0; i < 7; i++) rd("rot3");

    // overflow at full occupancy, then full rotation
    do_reset("rst2");
    for (int i = 0; i < 8; i++) wr("ld8", 16'(16'hA0 + i));
    wr("ovf", 16'h00FF);
    for (int i = 0; i < 8; i++) rd("rot8");

    // underflow and read/write conflict
    do_reset("rst3");
    rd("udf");
    wr("ld", 16'h1234); wr("ld", 16'h5678); wr("ld", 16'h9ABC);
    step("conf", 1'b1, 16'hDEAD, 1'b1, 1'b0);
    rd("after_conf");

    // write while running is dropped
    do_reset("rst4");
    wr("ld", 16'(  $urandom)); wr("ld", 16'($urandom));
    rd("run");
    wr("wrun", 16'h0055);
    for (int i = 0; i < 5; i++) rd("rot2");

    // clear mid-rotation (clear wins over a concurrent read), then reload a single word
    do_reset("rst5");
    for (int i = 0; i < 3; i++) wr("ld", 16'($urandom));
    for (int i = 0; i < 4; i++) rd("pre_clr");
    step("clr", 1'b0, '0, 1'b1, 1'b1);
    wr("reload", 16'h0001);
    rd("one");
    rd("one");

    // reset in the middle of a load
    do_reset("rst6");
    wr("ld", 16'h0AAA); wr("ld", 16'h0BBB);
    bus_a.npu_cbuf_write_en = 1'b1;
    bus_a.npu_cbuf_data_in  = 16'h0CCC;
    do_reset("rst_mid");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1)       do_reset("rnd_rst");
      else if (r < 6)  step("rnd_clr", 1'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      else if (r < 40) wr("rnd_wr", 16'($urandom));
      else if (r < 88) rd("rnd_rd");
      else if (r < 92) step("rnd_conf", 1'b1, 16'($urandom), 1'b1, 1'b0);
      else             step("rnd_idle", 1'b0, '0, 1'b0, 1'b0);
    end

    // wide instance at full occupancy: head == tail on every read
    do_reset("rst_b");
    check_val("b.empty_rst", 32'(bus_b.npu_cbuf_empty), 32'd1);
    for (int i = 0; i < DP2; i++) begin
      logic [DW2-1:0] d;
      d = DW2'($urandom);
      exp_b.push_back(d);
      bus_b.npu_cbuf_write_en = 1'b1;
      bus_b.npu_cbuf_data_in  = d;
      @(posedge clk); #1;
    end
    bus_b.npu_cbuf_write_en = 1'b0;
    check_val("b.full",  32'(bus_b.npu_cbuf_full),  32'd1);
    check_val("b.count", 32'(bus_b.npu_cbuf_count), 32'(DP2));
    bus_b.npu_cbuf_read_en = 1'b1;
    for (int i = 0; i < 3 * DP2; i++) begin
      @(posedge clk); #1;
      check_val("b.dout",  bus_b.npu_cbuf_data_out, exp_b[i % DP2]);
      check_val("b.valid", 32'(bus_b.npu_cbuf_data_valid), 32'd1);
      check_val("b.rev",   32'(bus_b.npu_cbuf_rev_done), 32'((i % DP2) == DP2 - 1));
    end
    bus_b.npu_cbuf_read_en = 1'b0;
    @(posedge clk); #1;
    check_val("b.valid_end", 32'(bus_b.npu_cbuf_data_valid), 32'd0);
    check_val("b.count_end", 32'(bus_b.npu_cbuf_count), 32'(DP2));
    check_val("b.err",       32'(bus_b.npu_cbuf_err), 32'd0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/npu_circ_buf_param.md
# npu_circ_buf_param

Parametrised circular buffer for NPU weight and schedule streams, the successor to the fixed 16-bit small/large circular buffers. Words are loaded once during configuration and then replayed indefinitely: every read returns the head word and writes it back at the tail in the same cycle, so the sequence rotates without loss. Storage is internal, and the block reports occupancy, revolution boundaries and sticky protocol errors. Full/empty are therefore enforced by the block rather than left to the caller. It sits between the config FIFO write interface and the NPU datapath.

## Interface
- DATA_W, 16, word width in bits
- DEPTH, 512, capacity in words; power of two, at least 2
- CNT_W, $clog2(DEPTH+1), width of the occupancy count
- CLK  in  1  global 100 MHz clock; all logic on its rising edge
- npu_rst  in  1  synchronous, active-high reset (global reset or NPU config change)
- npu_cbuf_clear  in  1  synchronous empty request; errors are retained
- npu_cbuf_write_en  in  1  load one word at the tail
- npu_cbuf_data_in  in  DATA_W  load data
- npu_cbuf_read_en  in  1  read the head word and recirculate it
- npu_cbuf_data_out  out  DATA_W  registered read data; reset value 0
- npu_cbuf_data_valid  out  1  data_out updated this cycle; reset value 0
- npu_cbuf_rev_done  out  1  word on data_out is the last word of a revolution; reset value 0
- npu_cbuf_count  out  CNT_W  words loaded; reset value 0
- npu_cbuf_full  out  1  count == DEPTH; reset value 0
- npu_cbuf_empty  out  1  count == 0; reset value 1
- npu_cbuf_err  out  4  sticky flags: [0] overflow, [1] underflow, [2] read/write conflict, [3] write while running; reset value 0

## Operation
- FSM states:
  - EMPTY (count 0)
  - LOAD (count > 0, no read since last load)
  - RUN (at least one read performed)
- FSM transitions:
  - EMPTY→LOAD on an accepted write
  - LOAD→RUN on an accepted read
  - any state→EMPTY on clear or reset
- Accepted write, allowed in EMPTY or LOAD when not full:
  - mem[tail] ← data_in
  - tail advances by 1 mod DEPTH
  - count increments by 1
- Accepted read, allowed in LOAD or RUN:
  - data_out ← mem[head]
  - mem[tail] ← mem[head]
  - head and tail each advance by 1 mod DEPTH
  - count is unchanged
- Revolution index:
  - rev_idx (CNT_W bits) resets to 0 on entering LOAD
  - increments on each accepted read and wraps to 0 after count-1
  - rev_done = 1 with data_valid when the read used rev_idx == count-1
- Error and priority rules:
  - write when full: word dropped, err[0] set
  - read when EMPTY: data_out holds, data_valid stays 0, err[1] set
  - write_en and read_en in the same cycle: neither executes, err[2] set
  - write in RUN: dropped, err[3] set
  - clear has priority over all of the above; it empties the buffer and sets no error
  - err bits clear only on npu_rst
- count = DEPTH is legal. Recirculation with head == tail writes the same word back to the same location, so the result is unchanged.

## Timing
- Read latency is 1 cycle: with read_en in cycle N, data_out, data_valid and rev_done are valid in cycle N+1. data_valid is a single-cycle pulse per accepted read.
- Back-to-back reads sustain 1 word per cycle with no bubbles. The recirculating write happens in the read cycle itself, with no delayed write-back.
- count, full, empty and err update in the cycle after the causing edge.
- Reset or clear mid-rotation:
  - next cycle: count 0, empty 1, head = tail = 0, state EMPTY
  - data_valid 0 in that cycle
  - data_out: reset forces 0; clear holds the last value
- Memory contents are not reset. Only pointers and count define validity.

## Structure
- Shared package npu_pkg holds:
  - the state enum {CBUF_EMPTY, CBUF_LOAD, CBUF_RUN}
  - err bit index constants CBUF_ERR_OVF/UDF/CONF/WRUN
- Sub-module npu_cbuf_ram: simple dual-port RAM with 1 write port, 1 registered read port, DATA_W x DEPTH, no reset.
- Pointer, count, revolution and FSM logic stay in the top level.

## Test plan
Bench parameters are DATA_W=16, DEPTH=8 unless noted.
- Reset, then load 0x0011, 0x0022, 0x0033 -> count=3, empty=0. Then 7 back-to-back reads -> data_out 11,22,33,11,22,33,11, each 1 cycle after read_en; rev_done on the 3rd and 6th outputs only.
- Load 8 words 0xA0..0xA7, then a 9th write 0xFF -> full=1, count=8, err=0001. Then 8 reads -> output A0..A7 in order, with no trace of 0xFF.
- Read in EMPTY -> data_valid stays 0 and err=0010. Then write_en and read_en together with 3 words loaded -> count still 3, err=0110.
- Load 2 words, read once (RUN), then write 0x55 -> count stays 2, err[3]=1, and the rotation continues with the original 2 words.
- Assert clear during continuous reads -> next cycle count=0, empty=1, data_valid=0, err unchanged. Reload 0x0001 -> the next read returns 0x0001 with rev_done=1.
- Assert npu_rst mid-load -> all outputs return to their reset values. Repeat the first scenario with DATA_W=32, DEPTH=4: 4 words rotate correctly at full occupancy, with head == tail at every read.
